// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Host-side driver for a pipelined multiply-accumulate unit. The host buffers up to
//   DEPTH operand pairs; on start the sequencer pulses the MAC clear, streams the pairs
//   one per cycle in write order, feeds LAT cycles of zero operands to flush the MAC
//   pipeline, then captures the MAC accumulator/overflow and pulses done.
//
//   Optional feature (macro MACSEQ_REPLAY_EN): CAPTURE keeps the buffer so a later start
//   replays the same pairs. Writes are locked out until a host clear, which is a start
//   issued in IDLE together with wr_en=1 and wr_a=wr_b=0.
//
// Ports:
//   clk, r            clock, synchronous active-high reset
//   wr_en/wr_a/wr_b   host write of one operand pair
//   start             run the buffered sequence
//   busy, full, count status: not IDLE, buffer full, pairs buffered
//   err               sticky: a write was dropped; cleared by reset or accepted start
//   done              one-cycle pulse, res_acc/res_of valid
//   res_acc, res_of   captured MAC accumulator and overflow
//   mac_clr           clear to the MAC (drives its reset)
//   mac_a, mac_b      operands to the MAC
//   mac_acc, mac_of   MAC accumulator and overflow flag
module mac_operand_sequencer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             r,
    input  logic             wr_en,
    input  logic [DW-1:0]    wr_a,
    input  logic [DW-1:0]    wr_b,
    input  logic             start,
    output logic             busy,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             err,
    output logic             done,
    output logic [AW-1:0]    res_acc,
    output logic             res_of,
    output logic             mac_clr,
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    input  logic [AW-1:0]    mac_acc,
    input  logic             mac_of
);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StCapture} state_e;

    // One down-counter serves both the stream length and the drain length.
    localparam int unsigned LAT_W = $clog2(LAT) + 1;
    localparam int unsigned CNT_W = (LAT_W > PTR_W + 1) ? LAT_W : PTR_W + 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               full_q, full_d;
    logic [AW-1:0]      res_acc_q, res_acc_d;
    logic               res_of_q, res_of_d;
    logic               mac_clr_q, mac_clr_d;
    logic [DW-1:0]      mac_a_q, mac_a_d;
    logic [DW-1:0]      mac_b_q, mac_b_d;
    logic               mem_we;
    logic               err_set;
    logic               wr_lock;
    logic               host_clr;

    logic [DW-1:0]      buf_a [DEPTH];
    logic [DW-1:0]      buf_b [DEPTH];

`ifdef MACSEQ_REPLAY_EN
    logic lock_q, lock_d;
    assign wr_lock  = lock_q;
    assign host_clr = (state_q == StIdle) && start && wr_en && (wr_a == '0) && (wr_b == '0);
`else
    assign wr_lock  = 1'b0;
    assign host_clr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        res_acc_d = res_acc_q;
        res_of_d  = res_of_q;
        mac_clr_d = 1'b0;
        mac_a_d   = '0;
        mac_b_d   = '0;
        mem_we    = 1'b0;
        err_set   = 1'b0;
`ifdef MACSEQ_REPLAY_EN
        lock_d    = lock_q;
`endif

        // The write is resolved before the FSM so a same-cycle start sees the new pair.
        if (wr_en && !host_clr) begin
            if ((state_q == StIdle) && (count_q < DEPTH_C) && !wr_lock) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (host_clr) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
`ifdef MACSEQ_REPLAY_EN
                    lock_d   = 1'b0;
`endif
                end else if (start && (count_d != '0)) begin
                    state_d   = StClear;
                    mac_clr_d = 1'b1;
                    err_d     = 1'b0;
                end
            end
            StClear: begin
                state_d  = StStream;
                mac_a_d  = buf_a[rd_ptr_q];
                mac_b_d  = buf_b[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = CNT_W'(count_q) - CNT_W'(1);
            end
            StStream: begin
                if (cnt_q == '0) begin
                    state_d = StDrain;
                    cnt_d   = CNT_W'(LAT - 1);
                end else begin
                    mac_a_d  = buf_a[rd_ptr_q];
                    mac_b_d  = buf_b[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StCapture: begin
                state_d   = StIdle;
                res_acc_d = mac_acc;
                res_of_d  = mac_of;
                done_d    = 1'b1;
                rd_ptr_d  = '0;
`ifdef MACSEQ_REPLAY_EN
                lock_d    = 1'b1;
`else
                count_d   = '0;
                wr_ptr_d  = '0;
`endif
            end
            default: state_d = StIdle;
        endcase

        // A dropped write wins over the clear from an accepted start.
        if (err_set) begin
            err_d = 1'b1;
        end

        busy_d = (state_d != StIdle);
        full_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= StIdle;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            res_acc_q <= '0;
            res_of_q  <= 1'b0;
            mac_clr_q <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
`ifdef MACSEQ_REPLAY_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            res_acc_q <= res_acc_d;
            res_of_q  <= res_of_d;
            mac_clr_q <= mac_clr_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
`ifdef MACSEQ_REPLAY_EN
            lock_q    <= lock_d;
`endif
        end
    end

    // Buffer storage is not reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_a[wr_ptr_q] <= wr_a;
            buf_b[wr_ptr_q] <= wr_b;
        end
    end

    assign busy    = busy_q;
    assign full    = full_q;
    assign count   = count_q;
    assign err     = err_q;
    assign done    = done_q;
    assign res_acc = res_acc_q;
    assign res_of  = res_of_q;
    assign mac_clr = mac_clr_q;
    assign mac_a   = mac_a_q;
    assign mac_b   = mac_b_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer (default build). A behavioural MAC
// drives mac_acc/mac_of; expected results come from summing the queued pairs.
module tb_mac_operand_sequencer;

    localparam int LAT   = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_a = '0;
    logic [7:0]  wr_b = '0;
    logic        start = 1'b0;
    logic        busy, full, err, done, res_of, mac_clr;
    logic [3:0]  count;
    logic [15:0] res_acc;
    logic [7:0]  mac_a, mac_b;
    logic [15:0] mac_acc;
    logic        mac_of;

    int total = 0;
    int bad = 0;

    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];
    logic [15:0] last_acc = '0;
    logic        last_of = 1'b0;

    mac_operand_sequencer dut (
        .clk(clk), .r(r), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .start(start),
        .busy(busy), .full(full), .count(count), .err(err), .done(done),
        .res_acc(res_acc), .res_of(res_of), .mac_clr(mac_clr), .mac_a(mac_a),
        .mac_b(mac_b), .mac_acc(mac_acc), .mac_of(mac_of)
    );

    always #5 clk = ~clk;

    // Behavioural two-stage MAC: product register, then accumulate with sticky carry.
    logic [15:0] m_p = '0;
    logic [15:0] m_acc = '0;
    logic        m_of = 1'b0;
    always @(posedge clk) begin
        if (mac_clr) begin
            m_p   <= '0;
            m_acc <= '0;
            m_of  <= 1'b0;
        end else begin
            m_p   <= mac_a * mac_b;
            m_acc <= m_acc + m_p;
            m_of  <= m_of | ((17'(m_acc) + 17'(m_p)) > 17'd65535);
        end
    end
    assign mac_acc = m_acc;
    assign mac_of  = m_of;

    task automatic write_pair(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (q_a.size() < DEPTH) begin
            q_a.push_back(a);
            q_b.push_back(b);
        end
    endtask

    // Runs one sequence and reports what was observed; callers do the comparisons.
    task automatic exec_seq(input bit with_wr, input logic [7:0] wa, input logic [7:0] wb,
                            output int done_k, output bit clr_ok, output bit data_ok,
                            output bit hold_ok, output bit err_clr, output bit busy_after,
                            output bit done_after, output logic [15:0] got_acc,
                            output logic got_of, output logic [15:0] exp_acc,
                            output logic exp_of);
        int n;
        logic [31:0] s;
        if (with_wr && q_a.size() < DEPTH) begin
            q_a.push_back(wa);
            q_b.push_back(wb);
        end
        n = q_a.size();
        s = 0;
        foreach (q_a[i]) s += q_a[i] * q_b[i];
        exp_acc = s[15:0];
        exp_of  = (s > 32'd65535);
        done_k = -1; clr_ok = 1; data_ok = 1; hold_ok = 1; err_clr = 0;
        busy_after = 1; done_after = 1; got_acc = 'x; got_of = 1'bx;
        @(negedge clk);
        start = 1'b1; wr_en = with_wr; wr_a = wa; wr_b = wb;
        for (int k = 1; k <= n + LAT + 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; wr_en = 1'b0;
                err_clr = (err === 1'b0);
                clr_ok &= (mac_clr === 1'b1) && (mac_a === 8'd0) && (mac_b === 8'd0);
            end else begin
                clr_ok &= (mac_clr === 1'b0);
            end
            if (k >= 2 && k <= 1 + n)
                data_ok &= (mac_a === q_a[k-2]) && (mac_b === q_b[k-2]);
            else if (k >= 2 + n && k <= 1 + n + LAT)
                data_ok &= (mac_a === 8'd0) && (mac_b === 8'd0);
            if (done_k < 0 && done === 1'b1) begin
                done_k = k; got_acc = res_acc; got_of = res_of;
            end else if (done_k < 0) begin
                hold_ok &= (res_acc === last_acc) && (res_of === last_of);
            end else if (k == done_k + 1) begin
                busy_after = busy; done_after = done;
                break;
            end
        end
        q_a.delete(); q_b.delete();
        last_acc = exp_acc; last_of = exp_of;
    endtask

    task automatic test_reset;
        r = 1'b1;
        repeat (2) @(negedge clk);
        r = 1'b0;
        @(negedge clk);
        q_a.delete(); q_b.delete(); last_acc = '0; last_of = 1'b0;
        total++; if ({busy, full, err, done, mac_clr} !== 5'b0) begin bad++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, full, err, done, mac_clr}); end
        total++; if (count !== 4'd0) begin bad++;
            $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({res_acc, res_of, mac_a, mac_b} !== 33'd0) begin bad++;
            $display("FAIL reset_data got=%h exp=0", {res_acc, res_of, mac_a, mac_b}); end
    endtask

    // Runs one sequence and checks everything; name identifies the scenario.
    task automatic test_run(input string name, input bit with_wr, input logic [7:0] wa,
                            input logic [7:0] wb, input int exp_done);
        int dk; bit c_ok, d_ok, h_ok, e_ok, b_aft, d_aft;
        logic [15:0] ga, ea; logic go, eo;
        exec_seq(with_wr, wa, wb, dk, c_ok, d_ok, h_ok, e_ok, b_aft, d_aft, ga, go, ea, eo);
        total++; if (dk !== exp_done) begin bad++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, dk, exp_done); end
        total++; if (!c_ok) begin bad++; $display("FAIL %s mac_clr got=bad exp=one_pulse", name); end
        total++; if (!d_ok) begin bad++; $display("FAIL %s stream got=bad exp=pairs_then_zeros", name); end
        total++; if (!h_ok) begin bad++; $display("FAIL %s res_hold got=changed exp=held", name); end
        total++; if (!e_ok) begin bad++; $display("FAIL %s err_clear got=1 exp=0", name); end
        total++; if (ga !== ea) begin bad++; $display("FAIL %s res_acc got=%0d exp=%0d", name, ga, ea); end
        total++; if (go !== eo) begin bad++; $display("FAIL %s res_of got=%b exp=%b", name, go, eo); end
        total++; if (b_aft !== 1'b0 || d_aft !== 1'b0) begin bad++;
            $display("FAIL %s after_done got=busy%b/done%b exp=0/0", name, b_aft, d_aft); end
        total++; if (count !== 4'd0) begin bad++;
            $display("FAIL %s count_after got=%0d exp=0", name, count); end
    endtask

    task automatic test_directed;
        write_pair(6, 9); write_pair(5, 4); write_pair(9, 2); write_pair(3, 8);
        total++; if (count !== 4'd4) begin bad++; $display("FAIL dir_count got=%0d exp=4", count); end
        test_run("dir116", 0, 0, 0, 3 + 4 + LAT);
        total++; if (res_acc !== 16'd116) begin bad++; $display("FAIL dir116_const got=%0d exp=116", res_acc); end
        write_pair(255, 255); write_pair(40, 40);
        test_run("dir_ovf", 0, 0, 0, 3 + 2 + LAT);
        total++; if (res_acc !== 16'd1089 || res_of !== 1'b1) begin bad++;
            $display("FAIL dir_ovf_const got=%0d/%b exp=1089/1", res_acc, res_of); end
        write_pair(6, 7); write_pair(5, 5); write_pair(3, 11);
        test_run("dir100", 0, 0, 0, 3 + 3 + LAT);
        total++; if (res_acc !== 16'd100 || res_of !== 1'b0) begin bad++;
            $display("FAIL dir100_const got=%0d/%b exp=100/0", res_acc, res_of); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 8; i++) write_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        total++; if (full !== 1'b1 || count !== 4'd8 || err !== 1'b0) begin bad++;
            $display("FAIL full_after8 got=f%b c%0d e%b exp=f1 c8 e0", full, count, err); end
        write_pair(8'd200, 8'd200);
        total++; if (err !== 1'b1 || count !== 4'd8) begin bad++;
            $display("FAIL full_drop got=e%b c%0d exp=e1 c8", err, count); end
        test_run("full_run", 0, 0, 0, 3 + 8 + LAT);
        total++; if (full !== 1'b0) begin bad++; $display("FAIL full_clear got=%b exp=0", full); end
    endtask

    task automatic test_reset_mid;
        bit saw;
        write_pair(3, 4); write_pair(5, 6); write_pair(7, 8);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (mac_a !== 8'd5 || mac_b !== 8'd6) begin bad++;
            $display("FAIL mid_pair2 got=%0d,%0d exp=5,6", mac_a, mac_b); end
        r = 1'b1;
        @(negedge clk);
        r = 1'b0;
        q_a.delete(); q_b.delete(); last_acc = '0; last_of = 1'b0;
        total++; if (busy !== 1'b0 || count !== 4'd0 || mac_a !== 8'd0 || mac_b !== 8'd0) begin bad++;
            $display("FAIL mid_reset got=b%b c%0d a%0d b%0d exp=0", busy, count, mac_a, mac_b); end
        saw = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            saw |= (done !== 1'b0) || (busy !== 1'b0);
        end
        total++; if (saw) begin bad++; $display("FAIL mid_no_done got=activity exp=idle"); end
    endtask

    task automatic test_empty_start;
        bit saw;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        saw = (mac_clr !== 1'b0) || (busy !== 1'b0) || (done !== 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            saw |= (mac_clr !== 1'b0) || (busy !== 1'b0) || (done !== 1'b0);
        end
        total++; if (saw) begin bad++; $display("FAIL empty_start got=activity exp=idle"); end
    endtask

    task automatic test_same_cycle;
        write_pair(8'd12, 8'd13);
        test_run("same_cycle", 1, 8'd21, 8'd3, 3 + 2 + LAT);
    endtask

    task automatic test_random;
        int n;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++)
                write_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            test_run("random", 0, 0, 0, 3 + n + LAT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_full();
        test_reset_mid();
        test_empty_start();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Host-side driver for the pipelined 8x8 multiply-accumulate unit. Buffers up to DEPTH operand pairs written by a host. On start it issues the MAC clear pulse, streams the pairs one per cycle, and flushes the MAC pipeline with zero operands. It then captures the MAC's accumulated result and overflow flag and returns them to the host with a done pulse.

Parameters:
DW, 8, operand width (mac_a/mac_b, wr_a/wr_b)
AW, 16, accumulator width (mac_acc, res_acc)
DEPTH, 8, operand-pair buffer entries (power of 2)
PTR_W, 3, log2(DEPTH)
LAT, 2, MAC pipeline latency in cycles from last operand pair to final acc/of (>=1)

Ports:
clk  input  1  rising-edge clock
r  input  1  synchronous active-high reset
wr_en  input  1  host write of one operand pair
wr_a  input  DW  operand a to buffer
wr_b  input  DW  operand b to buffer
start  input  1  host request to run the buffered sequence
busy  output  1  high in any state other than IDLE
full  output  1  buffer holds DEPTH pairs
count  output  PTR_W+1  pairs currently buffered
err  output  1  sticky: a write was dropped (full or busy); cleared by r or accepted start
done  output  1  one-cycle pulse: res_acc/res_of valid
res_acc  output  AW  captured accumulator
res_of  output  1  captured overflow
mac_clr  output  1  clear to MAC (drives MAC reset input r)
mac_a  output  DW  operand a to MAC
mac_b  output  DW  operand b to MAC
mac_acc  input  AW  MAC accumulator
mac_of  input  1  MAC overflow flag

Behaviour:
- Reset (r=1 at posedge): state=IDLE; count=0; write/read pointers=0; busy=0; done=0; err=0; res_acc=0; res_of=0; mac_clr=0; mac_a=mac_b=0. Reset takes priority over every other input, including mid-sequence. The buffer contents need not be cleared.
- All outputs are registered.
- Writes:
  - Accepted only in IDLE with count<DEPTH: pair stored at wr_ptr, wr_ptr wraps mod DEPTH, count+1.
  - wr_en when full or busy: pair dropped, err<=1.
  - wr_en and start in the same IDLE cycle: the write is accepted first, and the sequence includes that pair.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CAPTURE.
  - IDLE: start=1 and post-write count>0 -> CLEAR, err<=0. start with count=0 is ignored (no done, stay IDLE).
  - CLEAR: mac_clr=1 and mac_a=mac_b=0 for exactly 1 cycle -> STREAM.
  - STREAM: mac_clr=0; one buffered pair per cycle on mac_a/mac_b in write order, from rd_ptr with wrap. Lasts exactly N cycles (N = count latched at start) -> DRAIN.
  - DRAIN: mac_a=mac_b=0 for exactly LAT cycles -> CAPTURE.
  - CAPTURE: res_acc<=mac_acc, res_of<=mac_of, done<=1 for 1 cycle; count<=0; pointers<=0 -> IDLE.
- Timing: start sampled at edge t gives mac_clr high in cycle t+1, pairs in cycles t+2..t+1+N, zeros in t+2+N..t+1+N+LAT, and done high in cycle t+3+N+LAT.
- start while busy: ignored.
- res_acc/res_of hold their values until the next CAPTURE or reset.
- mac_of is sampled only in CAPTURE. The sequencer neither saturates nor interprets the accumulator; res_acc is exactly the MAC's value.

Optional Feature:
MACSEQ_REPLAY_EN:
- Defined: CAPTURE does not clear count or the buffer. A later start replays the same pairs, and new writes are accepted only after a host clear. The host clear is a start with wr_en=1 and wr_a=wr_b=0 issued in IDLE, which empties the buffer without running a sequence.
- Undefined: count and pointers are cleared in CAPTURE as specified above, and wr_en together with start behaves normally.

Test Plan:
- Reset, write (6,9),(5,4),(9,2),(3,8), start -> mac_clr 1 cycle, 4 pairs in order, 2 zero cycles; done at start+3+4+2 with res_acc=116, res_of=0.
- Write (255,255),(40,40), start -> res_acc=1089 (66625 mod 65536), res_of=1; busy low the cycle after done.
- Write (6,7),(5,5),(3,11), start -> res_acc=100, res_of=0; the previous result (1089/1) holds until this capture.
- Write 9 pairs with DEPTH=8 -> full=1 after 8th, 9th dropped, err=1; start -> sum of the first 8 only, err cleared at start.
- Assert r during STREAM (2nd pair) -> next cycle state IDLE, busy=0, count=0, mac_a=mac_b=0, no done pulse.
- start with count=0 -> no mac_clr, busy stays 0, no done. wr_en and start in the same cycle with 1 pair buffered -> N=2 streamed.
